lcd_cmd_sequencer: RTL and testbench

LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

---
 rtl/lcd_cmd_sequencer.sv | 148 ++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// LCD command sequencer: queues CPU command words in a small FIFO and feeds
// them one at a time to the LCD engine, waiting for the engine's finish edge
// or a timeout before starting the next one.
module lcd_cmd_sequencer #(
  parameter int CMD_W = 31,
  parameter int DEPTH = 4,
  parameter int TO_W  = 20
) (
  input  logic                     clk,
  input  logic                     rstn_LCD_en,
  input  logic                     cmd_valid,
  input  logic [CMD_W-1:0]         cmd_data,
  output logic                     cmd_ready,
  input  logic                     abort,
  input  logic                     clr_err,
  output logic                     eng_en,
  output logic [CMD_W-1:0]         eng_cmd,
  input  logic                     eng_finish,
  output logic                     LCD_Flag,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done_pulse,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  // Counter value from which the next RUN edge reaches the 2^TO_W-1 limit.
  localparam logic [TO_W-1:0] TO_LAST  = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, TMO} state_e;

  state_e            state_q, state_d;
  logic [CMD_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CMD_W-1:0]  eng_cmd_q;
  logic [TO_W-1:0]   tmo_cnt_q;
  logic              fin_prev_q;
  logic              timeout_err_q;

  logic push, pop, fin_rise, tmo_hit;

  assign cmd_ready = (count_q < FULL_CNT);
  assign push      = cmd_valid & cmd_ready & ~abort;
  assign pop       = (state_q == IDLE) & (count_q != '0) & ~abort;
  assign fin_rise  = eng_finish & ~fin_prev_q;
  // Completion in the same cycle wins over the timeout.
  assign tmo_hit   = (state_q == RUN) & ~fin_rise & (tmo_cnt_q == TO_LAST);

  assign count       = count_q;
  assign eng_cmd     = eng_cmd_q;
  assign timeout_err = timeout_err_q;
  assign LCD_Flag    = eng_en;

  // State register.
  always_ff @(posedge clk or negedge rstn_LCD_en) begin
    if (!rstn_LCD_en) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (pop) state_d = LOAD;
        LOAD: state_d = RUN;
        RUN: begin
          if (fin_rise)     state_d = DONE;
          else if (tmo_hit) state_d = TMO;
        end
        DONE:    state_d = IDLE;
        TMO:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    eng_en     = 1'b0;
    done_pulse = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      RUN:     eng_en = 1'b1;
      DONE:    done_pulse = 1'b1;
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset since pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cmd_data;
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn_LCD_en) begin
    if (!rstn_LCD_en) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Command register: loaded on the IDLE pop, held until the next pop.
  always_ff @(posedge clk or negedge rstn_LCD_en) begin
    if (!rstn_LCD_en) eng_cmd_q <= '0;
    else if (pop)     eng_cmd_q <= mem[rd_ptr_q];
  end

  // Timeout counter: cleared in LOAD, counts every RUN cycle.
  always_ff @(posedge clk or negedge rstn_LCD_en) begin
    if (!rstn_LCD_en)          tmo_cnt_q <= '0;
    else if (state_q == LOAD)  tmo_cnt_q <= '0;
    else if (state_q == RUN)   tmo_cnt_q <= tmo_cnt_q + TO_W'(1);
  end

  // Finish history for rising-edge detection; a level held across RUN entry is not an edge.
  always_ff @(posedge clk or negedge rstn_LCD_en) begin
    if (!rstn_LCD_en) fin_prev_q <= 1'b0;
    else              fin_prev_q <= eng_finish;
  end

  // Sticky timeout flag: set on entry to TMO (set beats clear), untouched by abort.
  always_ff @(posedge clk or negedge rstn_LCD_en) begin
    if (!rstn_LCD_en)          timeout_err_q <= 1'b0;
    else if (tmo_hit && !abort) timeout_err_q <= 1'b1;
    else if (clr_err)          timeout_err_q <= 1'b0;
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with DEPTH=4 and a short TO_W=4 timeout.
module tb_lcd_cmd_sequencer;

  logic        clk;
  logic        rstn_LCD_en;
  logic        cmd_valid;
  logic [30:0] cmd_data;
  logic        cmd_ready;
  logic        abort;
  logic        clr_err;
  logic        eng_en;
  logic [30:0] eng_cmd;
  logic        eng_finish;
  logic        LCD_Flag;
  logic        busy;
  logic [2:0]  count;
  logic        done_pulse;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  logic [30:0] wv [6];

  lcd_cmd_sequencer #(.CMD_W(31), .DEPTH(4), .TO_W(4)) dut (
    .clk        (clk),
    .rstn_LCD_en(rstn_LCD_en),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .clr_err    (clr_err),
    .eng_en     (eng_en),
    .eng_cmd    (eng_cmd),
    .eng_finish (eng_finish),
    .LCD_Flag   (LCD_Flag),
    .busy       (busy),
    .count      (count),
    .done_pulse (done_pulse),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the engine to start, checks the command, then completes it.
  task automatic complete_one(input logic [30:0] exp);
    for (int i = 0; i < 20 && eng_en !== 1'b1; i++) tick();
    chk("start", eng_en, 1'b1);
    chk("cmd", eng_cmd, exp);
    eng_finish = 1'b1;
    tick();
    chk("done", done_pulse, 1'b1);
    chk("en_off", eng_en, 1'b0);
    eng_finish = 1'b0;
    tick();
    chk("done_1cyc", done_pulse, 1'b0);
  endtask

  initial begin
    wv[0] = 31'h0A; wv[1] = 31'h0B; wv[2] = 31'h0C;
    wv[3] = 31'h0D; wv[4] = 31'h0E; wv[5] = 31'h0F;

    rstn_LCD_en = 1'b0;
    cmd_valid   = 1'b0;
    cmd_data    = '0;
    abort       = 1'b0;
    clr_err     = 1'b0;
    eng_finish  = 1'b0;

    // Reset state
    #12;
    chk("rst_en", eng_en, 1'b0);
    chk("rst_flag", LCD_Flag, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_cmd", eng_cmd, 31'h0);
    chk("rst_done", done_pulse, 1'b0);
    rstn_LCD_en = 1'b1;
    tick();

    // Single command: eng_en two cycles after accept
    cmd_valid = 1'b1;
    cmd_data  = 31'h1234;
    tick();
    cmd_valid = 1'b0;
    chk("t1_en_w0", eng_en, 1'b0);
    chk("t1_count", count, 3'd1);
    tick();
    chk("t1_en_w1", eng_en, 1'b0);
    chk("t1_busy", busy, 1'b1);
    tick();
    chk("t1_en_w2", eng_en, 1'b1);
    chk("t1_flag", LCD_Flag, 1'b1);
    complete_one(31'h1234);
    chk("t1_idle", busy, 1'b0);

    // Fill queue while engine is busy; sixth offer is dropped
    cmd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cmd_data = wv[k];
      tick();
      if (k == 4) begin
        chk("t2_full_cnt", count, 3'd4);
        chk("t2_not_ready", cmd_ready, 1'b0);
      end
    end
    cmd_valid = 1'b0;
    chk("t2_drop_cnt", count, 3'd4);
    chk("t2_running", eng_en, 1'b1);
    chk("t2_head", eng_cmd, 31'h0A);
    for (int k = 0; k < 5; k++) complete_one(wv[k]);
    tick();
    chk("t2_empty", count, 3'd0);
    chk("t2_idle", busy, 1'b0);

    // Timeout with eng_finish stuck low
    cmd_valid = 1'b1;
    cmd_data  = 31'h111;
    tick();
    cmd_data  = 31'h222;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t3_run", eng_en, 1'b1);
    chk("t3_cmd1", eng_cmd, 31'h111);
    repeat (14) tick();
    chk("t3_still_run", eng_en, 1'b1);
    chk("t3_no_err_yet", timeout_err, 1'b0);
    tick();
    chk("t3_tmo_en", eng_en, 1'b0);
    chk("t3_tmo_err", timeout_err, 1'b1);
    chk("t3_tmo_nodone", done_pulse, 1'b0);
    chk("t3_tmo_busy", busy, 1'b1);
    repeat (3) tick();
    chk("t3_next_run", eng_en, 1'b1);
    chk("t3_cmd2", eng_cmd, 31'h222);
    chk("t3_err_sticky", timeout_err, 1'b1);
    complete_one(31'h222);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_clr", timeout_err, 1'b0);

    // Abort with 3 queued and 1 running; concurrent push discarded
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cmd_data = wv[k];
      tick();
    end
    chk("t4_cnt3", count, 3'd3);
    chk("t4_run", eng_en, 1'b1);
    abort    = 1'b1;
    cmd_data = 31'h7FFF;
    tick();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    chk("t4_cnt0", count, 3'd0);
    chk("t4_en0", eng_en, 1'b0);
    chk("t4_idle", busy, 1'b0);
    chk("t4_nodone", done_pulse, 1'b0);
    chk("t4_terr", timeout_err, 1'b0);
    tick();
    chk("t4_nodone2", done_pulse, 1'b0);
    chk("t4_stay_idle", busy, 1'b0);
    chk("t4_cnt_stay", count, 3'd0);

    // eng_finish held high into RUN does not complete
    eng_finish = 1'b1;
    cmd_valid  = 1'b1;
    cmd_data   = 31'h5A5;
    tick();
    cmd_valid = 1'b0;
    repeat (2) tick();
    chk("t5_run", eng_en, 1'b1);
    repeat (2) tick();
    chk("t5_held_run", eng_en, 1'b1);
    chk("t5_held_nodone", done_pulse, 1'b0);
    eng_finish = 1'b0;
    tick();
    chk("t5_low_run", eng_en, 1'b1);
    chk("t5_low_nodone", done_pulse, 1'b0);
    complete_one(31'h5A5);

    // Asynchronous reset mid-RUN
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_data = wv[k];
      tick();
    end
    cmd_valid = 1'b0;
    chk("t6_run", eng_en, 1'b1);
    chk("t6_cnt2", count, 3'd2);
    #2;
    rstn_LCD_en = 1'b0;
    #1;
    chk("t6_en0", eng_en, 1'b0);
    chk("t6_flag0", LCD_Flag, 1'b0);
    chk("t6_cnt0", count, 3'd0);
    chk("t6_busy0", busy, 1'b0);
    #2;
    rstn_LCD_en = 1'b1;
    tick();
    chk("t6_after_busy", busy, 1'b0);
    chk("t6_after_cnt", count, 3'd0);
    chk("t6_after_en", eng_en, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
